uart_tx_packet: RTL
===================

Name: uart_tx_packet

Overview:
- Parametrised successor to the fixed 14-byte string transmitter.
- Transmits 0..MAX_BYTES bytes from a latched parallel buffer, with selectable byte order, configurable stop bits and inter-byte gap, and abort support.
- Contains its own resettable 8N1-style bit serializer; it does not instantiate the legacy uart_tx.
- Sits between the LCD/debug command logic and the board UART pin.

Parameters:
- CLOCKS_PER_BIT, 10, i_clock cycles per UART bit (>=2).
- MAX_BYTES, 16, buffer depth in bytes (>=1).
- STOP_BITS, 1, stop bits per frame (1 or 2).
- GAP_CLOCKS, 0, idle-high i_clock cycles inserted between consecutive frames of one packet.
- LEN_W, $clog2(MAX_BYTES+1), width of the length port (derived; do not override).

Ports:
- i_clock  in  1  system clock, rising edge.
- i_reset  in  1  asynchronous reset, active-high.
- i_txBegin  in  1  start request, sampled only in IDLE.
- i_txData  in  8*MAX_BYTES  packet; byte k = bits [8k+7:8k].
- i_txDataLength  in  LEN_W  number of bytes to send.
- i_msbFirst  in  1  1: send byte L-1 down to byte 0 (legacy order); 0: send byte 0 up to byte L-1.
- i_abort  in  1  stop the packet after the current frame.
- o_txBusy  out  1  high from acceptance until the DONE cycle.
- o_txSerial  out  1  UART line, idles high.
- o_txDone  out  1  one-cycle completion pulse.
- o_aborted  out  1  qualifies o_txDone; high if the packet was cut short.
- o_bytesSent  out  LEN_W  frames fully sent in the current/last packet.

Behaviour:
- Reset (asynchronous, any state, mid-frame included):
  - State = IDLE; o_txSerial=1; o_txBusy=0; o_txDone=0; o_aborted=0; o_bytesSent=0.
  - Any partial frame is truncated immediately.
- States: IDLE, START, DATA, PARITY (only with the optional feature), STOP, GAP, DONE.
- IDLE:
  - o_txBusy=0, o_txSerial=1.
  - On i_txBegin=1: latch i_txData, i_msbFirst, and L = min(i_txDataLength, MAX_BYTES); clear o_bytesSent and o_aborted.
  - If L=0: go to DONE. Otherwise go to START.
  - o_txBusy=1 from the next cycle.
- START: o_txSerial=0 for CLOCKS_PER_BIT cycles.
  - The first start bit begins the cycle after i_txBegin is sampled (latency 1).
- DATA: 8 bits, LSB first, each CLOCKS_PER_BIT cycles.
- STOP: o_txSerial=1 for STOP_BITS*CLOCKS_PER_BIT cycles. At the end of STOP, o_bytesSent increments. Then:
  - if o_bytesSent==L or abort is pending: go to DONE;
  - else if GAP_CLOCKS>0: go to GAP;
  - else go to START of the next byte, with no idle cycle.
- GAP: o_txSerial=1 for GAP_CLOCKS cycles, then START. An abort pending at the end of GAP goes to DONE instead.
- Abort:
  - i_abort=1 in any busy state sets an internal pending flag.
  - The frame in progress always completes, with full stop bits; no further frame starts.
  - DONE then asserts o_aborted=1. i_abort in IDLE is ignored.
  - Abort on the last byte: o_aborted=1 even though all L bytes were sent.
- DONE: exactly one cycle.
  - o_txDone=1, o_txBusy=0, o_txSerial=1, then IDLE.
  - i_txBegin during DONE is ignored; it is accepted from the following cycle.
  - o_aborted and o_bytesSent hold until the next acceptance or reset.
- Byte selection: index counter of width LEN_W.
  - msbFirst: start at L-1, decrement.
  - Otherwise: start at 0, increment.
  - The buffer must never be indexed past MAX_BYTES-1.
- i_txData changes while busy have no effect (latched copy).
- Packet duration for L>=1, no abort: L*(1+8+STOP_BITS)*CLOCKS_PER_BIT + (L-1)*GAP_CLOCKS cycles of busy, plus the DONE cycle.

Optional Feature:
- UART_TX_PARITY_EN defined:
  - A PARITY state follows DATA and drives one even-parity bit (XOR of the 8 data bits) for CLOCKS_PER_BIT cycles.
  - Frame = 1+8+1+STOP_BITS bits.
- Not defined: no PARITY state and no parity logic; frame = 1+8+STOP_BITS bits.

Test Plan:
- CPB=4, MAX_BYTES=4, STOP=1, GAP=0; L=2, data 0x0000_4142, msbFirst=1 -> frames 0x42 then 0x41 back-to-back; busy for 80 cycles; done pulse on cycle 81; bytesSent=2, aborted=0.
- Same setup, msbFirst=0, L=3, data 0x0033_2211 -> frames 0x11, 0x22, 0x33 in order.
- GAP_CLOCKS=5, L=2 -> exactly 5 high cycles between the first stop bit and the second start bit; busy lasts 85 cycles.
- L=0 -> one busy cycle, then done pulse, serial line never low; L=7 with MAX_BYTES=4 -> exactly 4 frames sent.
- i_abort pulsed mid-data of byte 1 of a 4-byte packet -> byte 1 completes with its stop bit, no byte 2; done with aborted=1, bytesSent=2.
- i_reset asserted mid-DATA -> o_txSerial=1 and o_txBusy=0 asynchronously; next i_txBegin after reset sends a clean full packet.

Source files
------------

// File: rtl/uart_tx_packet_if.sv
// Handshake/data bundle between the command logic (master) and uart_tx_packet (slave).
interface uart_tx_packet_if #(
    parameter int MAX_BYTES = 16,
    parameter int LEN_W     = $clog2(MAX_BYTES + 1)
);
    logic                   i_txBegin;
    logic [8*MAX_BYTES-1:0] i_txData;
    logic [LEN_W-1:0]       i_txDataLength;
    logic                   i_msbFirst;
    logic                   i_abort;
    logic                   o_txBusy;
    logic                   o_txSerial;
    logic                   o_txDone;
    logic                   o_aborted;
    logic [LEN_W-1:0]       o_bytesSent;

    modport master (
        output i_txBegin, i_txData, i_txDataLength, i_msbFirst, i_abort,
        input  o_txBusy, o_txSerial, o_txDone, o_aborted, o_bytesSent
    );

    modport slave (
        input  i_txBegin, i_txData, i_txDataLength, i_msbFirst, i_abort,
        output o_txBusy, o_txSerial, o_txDone, o_aborted, o_bytesSent
    );
endinterface

// File: rtl/uart_tx_packet.sv
// Packet UART transmitter: sends 0..MAX_BYTES latched bytes as 8N1-style frames with abort.
// Define UART_TX_PARITY_EN to add an even-parity bit after the data bits of every frame.
module uart_tx_packet #(
    parameter int CLOCKS_PER_BIT = 10,
    parameter int MAX_BYTES      = 16,
    parameter int STOP_BITS      = 1,
    parameter int GAP_CLOCKS     = 0,
    parameter int LEN_W          = $clog2(MAX_BYTES + 1)
) (
    input  logic             i_clock,
    input  logic             i_reset,
    uart_tx_packet_if.slave  bus
);
    localparam int STOP_CYC = STOP_BITS * CLOCKS_PER_BIT;
    localparam int TMAX     = (STOP_CYC > GAP_CLOCKS) ? STOP_CYC : GAP_CLOCKS;
    localparam int TMR_W    = $clog2(TMAX + 1);
    localparam int IDX_W    = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;

    typedef logic [TMR_W-1:0] tmr_t;
    localparam tmr_t BIT_LOAD  = tmr_t'(CLOCKS_PER_BIT - 1);
    localparam tmr_t STOP_LOAD = tmr_t'(STOP_CYC - 1);
    localparam tmr_t GAP_LOAD  = tmr_t'((GAP_CLOCKS > 0) ? GAP_CLOCKS - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP, S_GAP, S_DONE
    } state_e;

    state_e                    state_q;
    tmr_t                      timer_q;
    logic [2:0]                bit_q;
    logic [7:0]                shift_q;
    logic [LEN_W-1:0]          idx_q, len_q, sent_q;
    logic                      msb_q, abort_pend_q, aborted_q;
    logic                      busy_q, done_q, serial_q;
    logic [MAX_BYTES-1:0][7:0] buf_q;
`ifdef UART_TX_PARITY_EN
    logic                      parity_q;
`endif

    logic [LEN_W-1:0] len_d, idx_d, sent_d, idx_next;
    logic [IDX_W-1:0] cur_idx;
    logic [7:0]       cur_byte;
    logic             abort_now, timer_done;

    assign len_d      = (bus.i_txDataLength > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES)
                                                                 : bus.i_txDataLength;
    assign idx_d      = bus.i_msbFirst ? len_d - 1'b1 : '0;
    assign sent_d     = sent_q + 1'b1;
    assign idx_next   = msb_q ? idx_q - 1'b1 : idx_q + 1'b1;
    // Clamp keeps the buffer select in range even for the wrapped index of an empty packet.
    assign cur_idx    = (idx_q < LEN_W'(MAX_BYTES)) ? IDX_W'(idx_q) : '0;
    assign cur_byte   = buf_q[cur_idx];
    assign abort_now  = abort_pend_q | bus.i_abort;
    assign timer_done = (timer_q == '0);

    // NOTE: the packet buffer has no reset; it is only read after a fresh acceptance loads it.
    always_ff @(posedge i_clock) begin
        if (state_q == S_IDLE && bus.i_txBegin) begin
            buf_q <= bus.i_txData;
        end
    end

    // NOTE: all state and outputs use non-blocking updates so every branch sees pre-edge values.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            idx_q        <= '0;
            len_q        <= '0;
            sent_q       <= '0;
            msb_q        <= 1'b0;
            abort_pend_q <= 1'b0;
            aborted_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            serial_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (!timer_done) timer_q <= timer_q - 1'b1;
            if (state_q != S_IDLE && state_q != S_DONE && bus.i_abort) abort_pend_q <= 1'b1;

            case (state_q)
                S_IDLE: begin
                    if (bus.i_txBegin) begin
                        msb_q        <= bus.i_msbFirst;
                        len_q        <= len_d;
                        idx_q        <= idx_d;
                        sent_q       <= '0;
                        aborted_q    <= 1'b0;
                        abort_pend_q <= 1'b0;
                        busy_q       <= 1'b1;
                        if (len_d == '0) begin
                            // Empty packet: one idle-high busy cycle through GAP, then DONE.
                            state_q <= S_GAP;
                            timer_q <= '0;
                        end else begin
                            state_q  <= S_START;
                            serial_q <= 1'b0;
                            timer_q  <= BIT_LOAD;
                        end
                    end
                end
                S_START: begin
                    if (timer_done) begin
                        state_q  <= S_DATA;
                        serial_q <= cur_byte[0];
                        shift_q  <= {1'b0, cur_byte[7:1]};
                        bit_q    <= '0;
                        timer_q  <= BIT_LOAD;
`ifdef UART_TX_PARITY_EN
                        parity_q <= ^cur_byte;
`endif
                    end
                end
                S_DATA: begin
                    if (timer_done) begin
                        if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state_q  <= S_PARITY;
                            serial_q <= parity_q;
                            timer_q  <= BIT_LOAD;
`else
                            state_q  <= S_STOP;
                            serial_q <= 1'b1;
                            timer_q  <= STOP_LOAD;
`endif
                        end else begin
                            serial_q <= shift_q[0];
                            shift_q  <= {1'b0, shift_q[7:1]};
                            bit_q    <= bit_q + 3'd1;
                            timer_q  <= BIT_LOAD;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (timer_done) begin
                        state_q  <= S_STOP;
                        serial_q <= 1'b1;
                        timer_q  <= STOP_LOAD;
                    end
                end
`endif
                S_STOP: begin
                    if (timer_done) begin
                        sent_q <= sent_d;
                        if (sent_d == len_q || abort_now) begin
                            state_q   <= S_DONE;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            aborted_q <= abort_now;
                        end else begin
                            idx_q <= idx_next;
                            if (GAP_CLOCKS > 0) begin
                                state_q <= S_GAP;
                                timer_q <= GAP_LOAD;
                            end else begin
                                state_q  <= S_START;
                                serial_q <= 1'b0;
                                timer_q  <= BIT_LOAD;
                            end
                        end
                    end
                end
                S_GAP: begin
                    if (timer_done) begin
                        if (abort_now || sent_q == len_q) begin
                            state_q   <= S_DONE;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            aborted_q <= abort_now;
                        end else begin
                            state_q  <= S_START;
                            serial_q <= 1'b0;
                            timer_q  <= BIT_LOAD;
                        end
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.o_txBusy    = busy_q;
    assign bus.o_txSerial  = serial_q;
    assign bus.o_txDone    = done_q;
    assign bus.o_aborted   = aborted_q;
    assign bus.o_bytesSent = sent_q;
endmodule
